// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C write-only target.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_BYTE_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StData,
        StDataAck,
        StIgnore
    } i2c_rx_state_t;

endpackage

// File: rtl/i2c_slave_rx_if.sv
// Pin and fabric-side signal bundle of the I2C write-only target.
interface i2c_slave_rx_if #(
    parameter int unsigned CNT_W = 4
);
    import i2c_pkg::*;

    logic                  scl_in;
    logic                  sda_in;
    logic                  sda_oe;
    logic [I2C_BYTE_W-1:0] rx_data;
    logic                  rx_valid;
    logic [CNT_W-1:0]      rx_count;
    logic                  addressed;
    logic                  stop_pulse;

    modport master (
        output scl_in, sda_in,
        input  sda_oe, rx_data, rx_valid, rx_count, addressed, stop_pulse
    );

    modport slave (
        input  scl_in, sda_in,
        output sda_oe, rx_data, rx_valid, rx_count, addressed, stop_pulse
    );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA and derives SCL edges plus START/STOP conditions.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    input  logic mask,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_sync
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;
    logic [2:0] warm_q;
    logic       scl_s;
    logic       sda_s;
    logic       live;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            warm_q     <= 3'b000;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
            warm_q     <= {warm_q[1:0], 1'b1};
        end
    end

    // Events are suppressed until the pipeline holds real pin levels, so the
    // reset value of 1 cannot fake a START against a bus already in progress.
    assign live  = warm_q[2];
    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];

    always_comb begin
        sda_sync  = sda_s;
        scl_rise  = live & scl_s & ~scl_prev_q;
        scl_fall  = live & ~scl_s & scl_prev_q;
        start_det = live & ~mask & scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        stop_det  = live & ~mask & scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    end

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: address match, ACK generation and byte delivery.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50,
    parameter int unsigned           CNT_W      = 4
) (
    input logic            clk,
    input logic            rst,
    i2c_slave_rx_if.slave  bus
);

    i2c_rx_state_t         state_q, state_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d, shift_next;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic                  bit_done_q, bit_done_d;
    logic                  sda_oe_q, sda_oe_d;
    logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [CNT_W-1:0]      rx_count_q, rx_count_d;
    logic                  addressed_q, addressed_d;
    logic                  stop_pulse_q, stop_pulse_d;

    logic scl_rise, scl_fall, start_det, stop_det, sda_sync;
    logic addr_match;

    i2c_line_sync u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (bus.scl_in),
        .sda_in    (bus.sda_in),
        .mask      (sda_oe_q),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_sync  (sda_sync)
    );

    assign shift_next = {shift_q[I2C_BYTE_W-2:0], sda_sync};
    assign addr_match = (shift_next[I2C_BYTE_W-1:1] == SLAVE_ADDR) && !shift_next[0];

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        bit_done_d   = bit_done_q;
        sda_oe_d     = sda_oe_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_count_d   = rx_count_q;
        addressed_d  = addressed_q;
        stop_pulse_d = 1'b0;

        if (stop_det) begin
            state_d      = StIdle;
            sda_oe_d     = 1'b0;
            addressed_d  = 1'b0;
            stop_pulse_d = addressed_q;
        end else if (start_det) begin
            state_d     = StAddr;
            shift_d     = '0;
            bit_cnt_d   = 3'd0;
            bit_done_d  = 1'b0;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAddr: begin
                    if (scl_rise && !bit_done_q) begin
                        shift_d = shift_next;
                        if (bit_cnt_q == 3'd7) begin
                            if (addr_match) bit_done_d = 1'b1;
                            else            state_d    = StIgnore;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else if (scl_fall && bit_done_q) begin
                        sda_oe_d    = 1'b1;
                        addressed_d = 1'b1;
                        rx_count_d  = '0;
                        state_d     = StAddrAck;
                    end
                end
                StAddrAck, StDataAck: begin
                    if (scl_fall) begin
                        sda_oe_d   = 1'b0;
                        bit_cnt_d  = 3'd0;
                        bit_done_d = 1'b0;
                        state_d    = StData;
                    end
                end
                StData: begin
                    if (scl_rise && !bit_done_q) begin
                        shift_d = shift_next;
                        if (bit_cnt_q == 3'd7) bit_done_d = 1'b1;
                        else                   bit_cnt_d  = bit_cnt_q + 3'd1;
                    end else if (scl_fall && bit_done_q) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        if (rx_count_q != '1) rx_count_d = rx_count_q + 1'b1;
                        sda_oe_d   = 1'b1;
                        state_d    = StDataAck;
                    end
                end
                StIgnore: sda_oe_d = 1'b0;
                default:  state_d  = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            bit_cnt_q    <= 3'd0;
            bit_done_q   <= 1'b0;
            sda_oe_q     <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_count_q   <= '0;
            addressed_q  <= 1'b0;
            stop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_done_q   <= bit_done_d;
            sda_oe_q     <= sda_oe_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_count_q   <= rx_count_d;
            addressed_q  <= addressed_d;
            stop_pulse_q <= stop_pulse_d;
        end
    end

    assign bus.sda_oe     = sda_oe_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.rx_count   = rx_count_q;
    assign bus.addressed  = addressed_q;
    assign bus.stop_pulse = stop_pulse_q;

endmodule
